// File: rtl/l1_arb_pkg.sv
// Shared encodings and width helpers for the L1 memory arbiter and its burst address generator.
package l1_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_BEAT_W      = $clog2(DEF_BLOCK_WORDS);
    localparam int DEF_OFF_W       = $clog2(DEF_BLOCK_WORDS * (DEF_DATA_W / 8));

    // Beat counter width; BLOCK_WORDS is a power of two >= 2.
    function automatic int beat_width(input int block_words);
        return $clog2(block_words);
    endfunction

    // Byte-offset bits inside one block.
    function automatic int off_width(input int block_words, input int data_w);
        return $clog2(block_words * (data_w / 8));
    endfunction

endpackage

// File: rtl/l1_mem_arbiter_burst_addr_gen.sv
// Beat counter plus base + beat*WB address generation for one block burst.
module burst_addr_gen
    import l1_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int BW = beat_width(BLOCK_WORDS);
    localparam int OW = off_width(BLOCK_WORDS, DATA_W);
    localparam int WS = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OW) - 64'd1);

    logic [ADDR_W-1:0] base;
    logic [BW-1:0]     beat;

    always_ff @(posedge clock) begin
        if (reset) begin
            base <= '0;
            beat <= '0;
        end else if (load) begin
            base <= base_addr & ~OFF_MASK;
            beat <= '0;
        end else if (advance) begin
            beat <= beat + 1'b1;
        end
    end

    // Base is block aligned, so the offset never carries out of the block.
    assign addr = base + (ADDR_W'(beat) << WS);
    assign last = &beat;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one memory port between I-side refills and D-side refills/writebacks as fixed-length bursts.
// Build option: ARB_RR_EN selects round-robin on contention; otherwise D has fixed priority.
module l1_mem_arbiter
    import l1_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    state_t            state, state_nxt;
    owner_t            owner, grant;
    logic              we_q;
    logic              load, accept, last;
    logic [ADDR_W-1:0] beat_addr;

    assign load   = (state == ST_IDLE) && (i_req || d_req);
    assign accept = (state == ST_BURST) && mem_ready;

`ifdef ARB_RR_EN
    owner_t last_grant;

    always_ff @(posedge clock) begin
        if (reset)     last_grant <= OWN_I;
        else if (load) last_grant <= grant;
    end
`endif

    always_comb begin
        grant = OWN_I;
        if (d_req && !i_req) begin
            grant = OWN_D;
        end else if (d_req && i_req) begin
`ifdef ARB_RR_EN
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
`else
            grant = OWN_D;
`endif
        end
    end

    burst_addr_gen #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .base_addr ((grant == OWN_D) ? d_addr : i_addr),
        .advance   (accept),
        .addr      (beat_addr),
        .last      (last)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_req || d_req)  state_nxt = ST_BURST;
            ST_BURST: if (accept && last)  state_nxt = ST_DONE;
            ST_DONE:                       state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= OWN_I;
            we_q  <= 1'b0;
        end else if (load) begin
            owner <= grant;
            we_q  <= (grant == OWN_D) && d_we;
        end
    end

    always_comb begin
        mem_req   = (state == ST_BURST);
        mem_we    = mem_req && we_q;
        mem_addr  = mem_req ? beat_addr : '0;
        mem_wdata = (mem_req && owner == OWN_D && we_q) ? d_wdata : '0;
        d_wnext   = mem_req && (owner == OWN_D) && we_q && mem_ready;
        i_done    = (state == ST_DONE) && (owner == OWN_I);
        d_done    = (state == ST_DONE) && (owner == OWN_D);
        busy      = (state != ST_IDLE);
    end

    // Refill data lands one cycle after the beat is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_rdata  <= '0;
            i_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_rvalid <= 1'b0;
        end else begin
            i_rvalid <= accept && (owner == OWN_I);
            d_rvalid <= accept && (owner == OWN_D) && !we_q;
            if (accept && owner == OWN_I)          i_rdata <= mem_rdata;
            if (accept && owner == OWN_D && !we_q) d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: directed bursts, contention, mid-burst reset and memory stall.
module tb_l1_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
    logic        mem_req, mem_we, mem_ready, busy;

    always #5 clock = ~clock;

    l1_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wnext   (d_wnext),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    // Memory model: each word reads back as a tag plus its own address.
    assign mem_rdata = mem_req ? (32'hC0DE_0000 | mem_addr) : 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_mem[$];
    logic [31:0] exp_i[$], exp_d[$];
    logic        rdy_q[$];
    logic [31:0] wq[$];
    int          n_idone = 0, n_ddone = 0, n_wnext = 0;
    int          checks = 0, failures = 0;
    beat_t       mon_e;
    logic [31:0] mon_w;

    function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void push_burst(input bit d, input bit we, input logic [31:0] base,
                                       input logic [31:0] w0);
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = base + 32'(4 * k);
            exp_mem.push_back({we, a, we ? (w0 + 32'(k)) : 32'h0});
            if (!we) begin
                if (d) exp_d.push_back(32'hC0DE_0000 | a);
                else   exp_i.push_back(32'hC0DE_0000 | a);
            end
        end
        if (d) n_ddone++; else n_idone++;
        if (d && we) n_wnext += 4;
    endfunction

    // Memory ready responder: scripted values while a beat is pending, otherwise ready.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (mem_req === 1'b1 && rdy_q.size() > 0) mem_ready = rdy_q.pop_front();
            else                                       mem_ready = 1'b1;
        end
    end

    // D-side write data source: advances to the next word the cycle after d_wnext.
    initial begin
        bit wn;
        d_wdata = 32'h0;
        forever begin
            @(negedge clock);
            wn = (d_wnext === 1'b1);
            @(posedge clock); #1;
            if (wn && wq.size() > 0) void'(wq.pop_front());
            d_wdata = (wq.size() > 0) ? wq[0] : 32'h0;
        end
    end

    always @(negedge clock) begin
        if (mem_req === 1'b1 && mem_ready === 1'b1) begin
            chk("mem_beat_pending", 96'(exp_mem.size() > 0), 96'd1);
            if (exp_mem.size() > 0) begin
                mon_e = exp_mem.pop_front();
                chk("mem_beat", {mem_we, mem_addr, mem_wdata}, mon_e);
            end
        end
        if (i_rvalid === 1'b1) begin
            chk("i_rvalid_pending", 96'(exp_i.size() > 0), 96'd1);
            if (exp_i.size() > 0) begin
                mon_w = exp_i.pop_front();
                chk("i_rdata", i_rdata, mon_w);
            end
        end
        if (d_rvalid === 1'b1) begin
            chk("d_rvalid_pending", 96'(exp_d.size() > 0), 96'd1);
            if (exp_d.size() > 0) begin
                mon_w = exp_d.pop_front();
                chk("d_rdata", d_rdata, mon_w);
            end
        end
        if (i_done === 1'b1) begin
            chk("i_done_pending", 96'(n_idone > 0), 96'd1);
            chk("i_done_with_rvalid", i_rvalid, 1);
            if (n_idone > 0) n_idone--;
        end
        if (d_done === 1'b1) begin
            chk("d_done_pending", 96'(n_ddone > 0), 96'd1);
            if (n_ddone > 0) n_ddone--;
        end
        if (d_wnext === 1'b1) begin
            chk("d_wnext_pending", 96'(n_wnext > 0), 96'd1);
            chk("d_wnext_ready", mem_ready, 1);
            if (n_wnext > 0) n_wnext--;
        end
    end

    // Holds a side's request until it has seen n done pulses, then drops it after the done cycle.
    task automatic hold_req(input bit d, input int n, output int t_first);
        int got = 0;
        int t = 0;
        t_first = 0;
        while (got < n && t < 400) begin
            @(negedge clock);
            t++;
            if (d ? (d_done === 1'b1) : (i_done === 1'b1)) begin
                got++;
                if (got == 1) t_first = t;
            end
        end
        chk(d ? "d_done_timeout" : "i_done_timeout", got, n);
        @(posedge clock); #1;
        if (d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"},   mem_req,   0);
        chk({tag, "_mem_we"},    mem_we,    0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rdata"},   i_rdata,   0);
        chk({tag, "_i_rvalid"},  i_rvalid,  0);
        chk({tag, "_i_done"},    i_done,    0);
        chk({tag, "_d_rdata"},   d_rdata,   0);
        chk({tag, "_d_rvalid"},  d_rvalid,  0);
        chk({tag, "_d_done"},    d_done,    0);
        chk({tag, "_d_wnext"},   d_wnext,   0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t2;
        logic [5:0] pat;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("rst");
        @(posedge clock); #1 reset = 1'b0;

        // I-only refill of the block containing 0x104, zero-wait memory.
        @(posedge clock); #1;
        push_burst(0, 0, 32'h100, 32'h0);
        i_addr = 32'h104; i_req = 1'b1;
        hold_req(0, 1, t);
        chk("i_burst_len", t, 6);
        repeat (2) @(posedge clock); #1;

        // D writeback at 0x200 with ready pattern 1,0,0,1,1,1.
        for (int k = 0; k < 4; k++) wq.push_back(32'hA0A0_0000 + 32'(k));
        @(posedge clock); #1;
        @(posedge clock); #1;
        pat = 6'b111001;
        for (int k = 0; k < 6; k++) rdy_q.push_back(pat[k]);
        push_burst(1, 1, 32'h200, 32'hA0A0_0000);
        d_addr = 32'h200; d_we = 1'b1; d_req = 1'b1;
        hold_req(1, 1, t);
        d_we = 1'b0;
        chk("wq_drained", wq.size(), 0);
        repeat (2) @(posedge clock); #1;

        // Contention from reset: both sides want two bursts each.
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0;
`ifdef ARB_RR_EN
        push_burst(1, 0, 32'h400, 32'h0);
        push_burst(0, 0, 32'h300, 32'h0);
        push_burst(1, 0, 32'h400, 32'h0);
        push_burst(0, 0, 32'h300, 32'h0);
`else
        push_burst(1, 0, 32'h400, 32'h0);
        push_burst(1, 0, 32'h400, 32'h0);
        push_burst(0, 0, 32'h300, 32'h0);
        push_burst(0, 0, 32'h300, 32'h0);
`endif
        i_req = 1'b1; d_req = 1'b1;
        fork
            hold_req(0, 2, t);
            hold_req(1, 2, t2);
        join
        repeat (2) @(posedge clock); #1;

        // Reset during beat 2 of a D refill at 0x500: beats 0..2 offered, only 0..1 returned.
        exp_mem.push_back({1'b0, 32'h500, 32'h0});
        exp_mem.push_back({1'b0, 32'h504, 32'h0});
        exp_mem.push_back({1'b0, 32'h508, 32'h0});
        exp_d.push_back(32'hC0DE_0500);
        exp_d.push_back(32'hC0DE_0504);
        d_addr = 32'h500; d_req = 1'b1;
        repeat (3) @(posedge clock); #1;
        reset = 1'b1; d_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_zero("rst_mid");
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        push_burst(1, 0, 32'h500, 32'h0);
        d_req = 1'b1;
        hold_req(1, 1, t);
        chk("d_restart_len", t, 6);
        repeat (2) @(posedge clock); #1;

        // I request dropped at beat 1: the burst still runs to completion.
        push_burst(0, 0, 32'h600, 32'h0);
        i_addr = 32'h60C; i_req = 1'b1;
        repeat (2) @(posedge clock); #1;
        i_req = 1'b0;
        hold_req(0, 1, t);
        repeat (2) @(posedge clock); #1;

        // Stalled memory for 10 cycles at beat 0 of an I refill at 0x700.
        for (int k = 0; k < 10; k++) rdy_q.push_back(1'b0);
        push_burst(0, 0, 32'h700, 32'h0);
        i_addr = 32'h708; i_req = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("stall_mem_req",  mem_req,  1);
            chk("stall_mem_addr", mem_addr, 32'h700);
            chk("stall_i_rvalid", i_rvalid, 0);
            chk("stall_busy",     busy,     1);
        end
        hold_req(0, 1, t);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("end_busy", busy, 0);
        chk("end_mem_q", exp_mem.size(), 0);
        chk("end_i_q", exp_i.size(), 0);
        chk("end_d_q", exp_d.size(), 0);
        chk("end_i_done", n_idone, 0);
        chk("end_d_done", n_ddone, 0);
        chk("end_wnext", n_wnext, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
